fb_port_arbiter: RTL and testbench

- Shares the single-port frame-buffer RAM between two requesters: the display scan reader (led_driver fetch path) and a host pixel writer (UART/bus update path).
- Display reads have absolute priority because scan timing is fixed.
- Host writes are queued in a small FIFO and issued in idle slots.
- Sits between led_driver / host interface and the frame-buffer RAM macro.

---
 rtl/fb_port_arbiter_pkg.sv | 34 +++
 rtl/fb_wr_fifo.sv | 60 ++++++
 rtl/fb_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_port_arbiter_pkg.sv
// fb_port_arbiter_pkg
// Shared constants for the frame-buffer port arbiter.
// Contents:
//   - default pixel address width, colour depth and matrix size
//   - grant encoding and the issue-stage state type
//   - FB_BANK_BITS: extra RAM address bits used for bank selection
// Optional feature macro: FB_DOUBLE_BUFFER_EN adds one bank-select address bit.
// There are no ports; every other file in the arbiter imports this package.
package fb_port_arbiter_pkg;

  // Matrix geometry defaults. A pixel address is {row[3:0], col[3:0]} and a pixel is RGB332.
  localparam int FB_ADDR_WIDTH  = 8;
  localparam int FB_COLOR_DEPTH = 8;
  localparam int FB_MATRIX_SIZE = 16;

  // Grant encoding of the registered issue stage.
  localparam logic [1:0] GNT_IDLE = 2'd0;
  localparam logic [1:0] GNT_RD   = 2'd1;
  localparam logic [1:0] GNT_WR   = 2'd2;

  typedef enum logic [1:0] {
    ISSUE_IDLE = GNT_IDLE,
    ISSUE_RD   = GNT_RD,
    ISSUE_WR   = GNT_WR
  } issue_t;

  // The double-buffered RAM carries the bank select as its top address bit.
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int FB_BANK_BITS = 1;
`else
  localparam int FB_BANK_BITS = 0;
`endif

endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo
// Synchronous FIFO with an occupancy count. It queues host pixel writes
// until the arbiter finds an idle RAM slot for them.
// Ports:
//   clk, rst   system clock; synchronous active-high reset that flushes the queue
//   push       enqueue push_data (ignored when full)
//   push_data  entry to enqueue
//   pop        dequeue the head entry (ignored when empty)
//   head       current head entry (combinational view of storage)
//   full       the queue holds DEPTH entries
//   empty      the queue holds no entries
//   count      occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
module fb_wr_fifo
  import fb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FB_ADDR_WIDTH + FB_COLOR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // Pointers carry one extra wrap bit above the index, so equal indices with
  // different wrap bits mean full and identical pointers mean empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // The reset flushes the queue through the pointers, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares the single-port frame-buffer RAM between the display scan reader
// and the host pixel writer. Display reads always win. Host writes wait in a
// small FIFO and go out in idle slots.
// Ports:
//   clk, rst             system clock; synchronous active-high reset
//   disp_rd_en/addr      display read request; data returns 2 cycles later
//   disp_rd_data/valid   read data, taken directly from ram_rdata
//   disp_frame_start     pulse at row-0 scan start (swap point)
//   host_wr_*            valid/ready pixel write channel
//   host_swap_req        request a front/back buffer swap
//   swap_done            one-cycle pulse when a swap is taken
//   wr_pending           queued host write count
//   ram_*                single-port RAM macro interface
// Optional feature macro: FB_DOUBLE_BUFFER_EN (double-buffered frame with bank swap).
// Without the macro, host_swap_req is ignored and swap_done stays 0.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH    = FB_COLOR_DEPTH,
  parameter int WR_FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                disp_rd_en,
  input  logic [ADDR_WIDTH-1:0]               disp_rd_addr,
  output logic [DATA_WIDTH-1:0]               disp_rd_data,
  output logic                                disp_rd_valid,
  input  logic                                disp_frame_start,
  input  logic                                host_wr_valid,
  output logic                                host_wr_ready,
  input  logic [ADDR_WIDTH-1:0]               host_wr_addr,
  input  logic [DATA_WIDTH-1:0]               host_wr_data,
  input  logic                                host_swap_req,
  output logic                                swap_done,
  output logic [$clog2(WR_FIFO_DEPTH):0]      wr_pending,
  output logic                                ram_en,
  output logic                                ram_we,
  output logic [ADDR_WIDTH+FB_BANK_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]               ram_wdata,
  input  logic [DATA_WIDTH-1:0]               ram_rdata
);

  localparam int RAM_AW = ADDR_WIDTH + FB_BANK_BITS;
  localparam int EW     = ADDR_WIDTH + DATA_WIDTH;

  issue_t                 issue_q;
  issue_t                 issue_d;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [EW-1:0]          fifo_head;
  logic                   rd_valid_q;
  logic [RAM_AW-1:0]      rd_addr_full;
  logic [RAM_AW-1:0]      wr_addr_full;

  assign fifo_push = host_wr_valid && host_wr_ready;

  fb_wr_fifo #(
    .DEPTH (WR_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({host_wr_addr, host_wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (wr_pending)
  );

`ifdef FB_DOUBLE_BUFFER_EN
  logic front_bank;
  logic swap_pending;
  logic swap_done_q;
  logic swap_take;

  // A swap is allowed only at a frame boundary, with the back buffer fully
  // drained: nothing queued and no write occupying the RAM this cycle.
  assign swap_take = disp_frame_start && swap_pending && fifo_empty && (issue_q != ISSUE_WR);

  // swap_pending is sticky, so repeated requests merge into one swap. A new
  // request arriving in the same cycle as a swap starts another pending swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done_q  <= 1'b0;
    end else begin
      if (swap_take) front_bank <= ~front_bank;
      swap_pending <= host_swap_req || (swap_pending && !swap_take);
      swap_done_q  <= swap_take;
    end
  end

  // Writes are closed while a swap is pending, so the back buffer drains.
  assign host_wr_ready = !rst && !fifo_full && !swap_pending;
  assign swap_done     = swap_done_q;
  assign rd_addr_full  = {front_bank, disp_rd_addr};
  assign wr_addr_full  = {~front_bank, fifo_head[EW-1 -: ADDR_WIDTH]};
`else
  logic unused_swap_inputs;

  assign unused_swap_inputs = host_swap_req ^ disp_frame_start;
  assign host_wr_ready      = !rst && !fifo_full;
  assign swap_done          = 1'b0;
  assign rd_addr_full       = disp_rd_addr;
  assign wr_addr_full       = fifo_head[EW-1 -: ADDR_WIDTH];
`endif

  // Grant decision: the display has absolute priority. The FIFO head is
  // popped in the grant cycle and its contents are registered into the RAM
  // address/data outputs at the same edge.
  always_comb begin
    issue_d  = ISSUE_IDLE;
    fifo_pop = 1'b0;
    if (disp_rd_en) begin
      issue_d = ISSUE_RD;
    end else if (!fifo_empty) begin
      issue_d  = ISSUE_WR;
      fifo_pop = 1'b1;
    end
  end

  // Issue-stage state register.
  always_ff @(posedge clk) begin
    if (rst) issue_q <= ISSUE_IDLE;
    else     issue_q <= issue_d;
  end

  // RAM address/data registers. They hold their value in idle slots, and a
  // read leaves the write data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (issue_d == ISSUE_RD) begin
      ram_addr <= rd_addr_full;
    end else if (issue_d == ISSUE_WR) begin
      ram_addr  <= wr_addr_full;
      ram_wdata <= fifo_head[DATA_WIDTH-1:0];
    end
  end

  // The RAM returns data one cycle after an issued read. This register lines
  // up the valid flag with that data. Reset clears it, which drops any
  // in-flight read.
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= (issue_q == ISSUE_RD);
  end

  assign ram_en        = (issue_q != ISSUE_IDLE);
  assign ram_we        = (issue_q == ISSUE_WR);
  assign disp_rd_valid = rd_valid_q;
  assign disp_rd_data  = ram_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
// Directed testbench for fb_port_arbiter with a behavioural single-port RAM.
// Covers reset values, grant priority, read latency, FIFO queuing and the
// full condition, and reset during a burst. With FB_DOUBLE_BUFFER_EN defined
// it also covers the immediate and the deferred bank swap.
module tb_fb_port_arbiter;
  import fb_port_arbiter_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int RAW = AW + FB_BANK_BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            disp_rd_en;
  logic [AW-1:0]   disp_rd_addr;
  logic [DW-1:0]   disp_rd_data;
  logic            disp_rd_valid;
  logic            disp_frame_start;
  logic            host_wr_valid;
  logic            host_wr_ready;
  logic [AW-1:0]   host_wr_addr;
  logic [DW-1:0]   host_wr_data;
  logic            host_swap_req;
  logic            swap_done;
  logic [2:0]      wr_pending;
  logic            ram_en;
  logic            ram_we;
  logic [RAW-1:0]  ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
  logic            preload;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rd_en;
    logic [7:0] rd_addr;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       en;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       valid;
    logic [7:0] rdata;
    logic       ready;
    int         pending;
  } vec_t;

  vec_t vt [16];

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .WR_FIFO_DEPTH (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .disp_rd_en       (disp_rd_en),
    .disp_rd_addr     (disp_rd_addr),
    .disp_rd_data     (disp_rd_data),
    .disp_rd_valid    (disp_rd_valid),
    .disp_frame_start (disp_frame_start),
    .host_wr_valid    (host_wr_valid),
    .host_wr_ready    (host_wr_ready),
    .host_wr_addr     (host_wr_addr),
    .host_wr_data     (host_wr_data),
    .host_swap_req    (host_swap_req),
    .swap_done        (swap_done),
    .wr_pending       (wr_pending),
    .ram_en           (ram_en),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata)
  );

  // Initial RAM contents: a few marked pixels, and elsewhere the address XOR 0xC3.
  function automatic logic [7:0] initVal(input logic [7:0] a);
    case (a)
      8'h12:   return 8'hA5;
      8'h13:   return 8'h5A;
      8'h20:   return 8'h11;
      8'h21:   return 8'h22;
      default: return a ^ 8'hC3;
    endcase
  endfunction

  // Behavioural single-port RAM with registered read data, one cycle after ram_en.
  logic [DW-1:0] mem [2**RAW];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2**RAW; i++) mem[i] <= initVal(8'(i));
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic rd, input logic [7:0] ra,
                               input logic wv, input logic [7:0] wa,
                               input logic [7:0] wd,
                               input logic fs = 1'b0, input logic sw = 1'b0);
    disp_rd_en       = rd;
    disp_rd_addr     = ra;
    host_wr_valid    = wv;
    host_wr_addr     = wa;
    host_wr_data     = wd;
    disp_frame_start = fs;
    host_swap_req    = sw;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int n_we;
    int n_valid;

    rst = 1'b1;
    preload = 1'b1;
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    preload = 1'b0;
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);

    // Outputs while reset is held.
    checkOutput("rst ram_en", ram_en, 0);
    checkOutput("rst ram_we", ram_we, 0);
    checkOutput("rst rd_valid", disp_rd_valid, 0);
    checkOutput("rst swap_done", swap_done, 0);
    checkOutput("rst ram_addr", ram_addr, 0);
    checkOutput("rst ram_wdata", ram_wdata, 0);
    checkOutput("rst wr_pending", wr_pending, 0);
    checkOutput("rst ready", host_wr_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("post-rst ready", host_wr_ready, 1);

    // Per-cycle vectors: priority, latency, queuing and FIFO full.
    vt[0]  = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0};
    vt[1]  = '{1, 8'h12, 0, 8'h00, 8'h00, 1, 0, 8'h12, 8'h00, 0, 8'h00, 1, 0};
    vt[2]  = '{1, 8'h13, 0, 8'h00, 8'h00, 1, 0, 8'h13, 8'h00, 1, 8'hA5, 1, 0};
    vt[3]  = '{0, 8'h00, 1, 8'h40, 8'h99, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 1, 1};
    vt[4]  = '{0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h99, 0, 8'h00, 1, 0};
    vt[5]  = '{1, 8'h20, 1, 8'h41, 8'h55, 1, 0, 8'h20, 8'h00, 0, 8'h00, 1, 1};
    vt[6]  = '{1, 8'h21, 1, 8'h42, 8'h66, 1, 0, 8'h21, 8'h00, 1, 8'h11, 1, 2};
    vt[7]  = '{1, 8'h12, 1, 8'h43, 8'h77, 1, 0, 8'h12, 8'h00, 1, 8'h22, 1, 3};
    vt[8]  = '{1, 8'h13, 1, 8'h44, 8'h88, 1, 0, 8'h13, 8'h00, 1, 8'hA5, 0, 4};
    vt[9]  = '{1, 8'h12, 1, 8'h45, 8'hAA, 1, 0, 8'h12, 8'h00, 1, 8'h5A, 0, 4};
    vt[10] = '{0, 8'h00, 1, 8'h45, 8'hAA, 1, 1, 8'h41, 8'h55, 1, 8'hA5, 1, 3};
    vt[11] = '{0, 8'h00, 1, 8'h45, 8'hAA, 1, 1, 8'h42, 8'h66, 0, 8'h00, 1, 3};
    vt[12] = '{0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 8'h43, 8'h77, 0, 8'h00, 1, 2};
    vt[13] = '{0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 8'h44, 8'h88, 0, 8'h00, 1, 1};
    vt[14] = '{0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 8'h45, 8'hAA, 0, 8'h00, 1, 0};
    vt[15] = '{0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vt[i].rd_en, vt[i].rd_addr, vt[i].wr_valid, vt[i].wr_addr, vt[i].wr_data);
      checkOutput($sformatf("vec%0d ram_en", i), ram_en, vt[i].en);
      checkOutput($sformatf("vec%0d ram_we", i), ram_we, vt[i].we);
      checkOutput($sformatf("vec%0d rd_valid", i), disp_rd_valid, vt[i].valid);
      checkOutput($sformatf("vec%0d ready", i), host_wr_ready, vt[i].ready);
      checkOutput($sformatf("vec%0d wr_pending", i), wr_pending, vt[i].pending);
      if (vt[i].en) checkOutput($sformatf("vec%0d ram_addr", i), ram_addr[7:0], vt[i].addr);
      if (vt[i].we) checkOutput($sformatf("vec%0d ram_wdata", i), ram_wdata, vt[i].wdata);
      if (vt[i].valid) checkOutput($sformatf("vec%0d rd_data", i), disp_rd_data, vt[i].rdata);
    end

    // Reset in the middle of a read burst, with three writes queued.
    applyStimulus(1, 8'h00, 1, 8'h50, 8'h01);
    applyStimulus(1, 8'h01, 1, 8'h51, 8'h02);
    applyStimulus(1, 8'h02, 1, 8'h52, 8'h03);
    checkOutput("midrst queued", wr_pending, 3);
    applyStimulus(1, 8'h03, 0, 8'h00, 8'h00);
    checkOutput("midrst rd issued", ram_en, 1);
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("midrst rd_valid", disp_rd_valid, 0);
    checkOutput("midrst wr_pending", wr_pending, 0);
    checkOutput("midrst ready", host_wr_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst ready after", host_wr_ready, 1);
    n_we = 0;
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
      if (ram_we) n_we++;
      if (disp_rd_valid) n_valid++;
    end
    checkOutput("midrst no ram_we", n_we, 0);
    checkOutput("midrst no valid", n_valid, 0);

    // 16-cycle read burst, with a host write presented in the middle of it.
    n_we = 0;
    n_valid = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), (i == 3), 8'h34, 8'h7E);
      if (ram_we) n_we++;
      if (disp_rd_valid) n_valid++;
      if (i == 3) checkOutput("burst wr queued", wr_pending, 1);
      if (i >= 1) begin
        checkOutput($sformatf("burst%0d valid", i), disp_rd_valid, 1);
        checkOutput($sformatf("burst%0d data", i), disp_rd_data, 8'(i - 1) ^ 8'hC3);
      end
    end
    checkOutput("burst no ram_we", n_we, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    if (disp_rd_valid) n_valid++;
    checkOutput("burst-end ram_we", ram_we, 1);
    checkOutput("burst-end ram_addr", ram_addr[7:0], 8'h34);
    checkOutput("burst-end ram_wdata", ram_wdata, 8'h7E);
    checkOutput("burst-end wr_pending", wr_pending, 0);
    checkOutput("burst last data", disp_rd_data, 8'h0F ^ 8'hC3);
    checkOutput("burst valid count", n_valid, 16);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("post-burst valid", disp_rd_valid, 0);
    checkOutput("post-burst ram_en", ram_en, 0);

`ifdef FB_DOUBLE_BUFFER_EN
    // Write to the back bank, then swap at a frame start with the FIFO empty.
    applyStimulus(0, 8'h00, 1, 8'h10, 8'hEE);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("swap wr addr", ram_addr, 9'h110);
    checkOutput("swap wr data", ram_wdata, 8'hEE);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("swap pending ready", host_wr_ready, 0);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("swap_done pulse", swap_done, 1);
    checkOutput("swap ready back", host_wr_ready, 1);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("swap_done cleared", swap_done, 0);
    applyStimulus(1, 8'h10, 0, 8'h00, 8'h00);
    checkOutput("swap rd addr bank1", ram_addr, 9'h110);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("swap rd valid", disp_rd_valid, 1);
    checkOutput("swap rd data", disp_rd_data, 8'hEE);

    // A frame start with two writes still queued defers the swap.
    applyStimulus(1, 8'h00, 1, 8'h20, 8'h31);
    applyStimulus(1, 8'h01, 1, 8'h21, 8'h32);
    applyStimulus(1, 8'h02, 0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("defer pending", wr_pending, 2);
    checkOutput("defer ready", host_wr_ready, 0);
    applyStimulus(1, 8'h03, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("defer rd addr", ram_addr, 9'h103);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("defer no swap", swap_done, 0);
    checkOutput("defer wr0 addr", ram_addr, 9'h020);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("defer wr1 addr", ram_addr, 9'h021);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("defer swap_done", swap_done, 1);
    applyStimulus(1, 8'h00, 0, 8'h00, 8'h00);
    checkOutput("defer rd addr bank0", ram_addr, 9'h000);
    checkOutput("defer ready back", host_wr_ready, 1);
`else
    // Without double buffering, swap requests have no effect.
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("noswap ready", host_wr_ready, 1);
    applyStimulus(0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("noswap swap_done", swap_done, 0);
    applyStimulus(1, 8'h10, 0, 8'h00, 8'h00);
    checkOutput("noswap rd addr", ram_addr, 8'h10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
